// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared lane geometry and state encoding for the beat loader
package nn_pkg;

  localparam int NN_LANES  = 50;
  localparam int NN_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/lane_buffer.sv
// rtl/lane_buffer.sv - LANES x BYTE_W fill register with indexed write and sync clear
module lane_buffer
  import nn_pkg::*;
#(
  parameter int LANES  = NN_LANES,
  parameter int BYTE_W = NN_BYTE_W,
  parameter int IDX_W  = idx_w(NN_LANES)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic [BYTE_W-1:0]       i_data,
  output logic [LANES*BYTE_W-1:0] o_data
);

  logic [LANES*BYTE_W-1:0] r_buf;

  // A write in the same cycle as a clear wins for its own lane.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf <= '0;
    end else begin
      if (i_clr) r_buf <= '0;
      if (i_we)  r_buf[i_idx*BYTE_W +: BYTE_W] <= i_data;
    end
  end

  assign o_data = r_buf;

endmodule

// File: rtl/nn_beat_loader.sv
// rtl/nn_beat_loader.sv - packs a byte stream into LANES-wide beats with frame length checks
module nn_beat_loader
  import nn_pkg::*;
#(
  parameter int LANES  = NN_LANES,
  parameter int BYTE_W = NN_BYTE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  input  logic [BYTE_W-1:0]       s_data,
  input  logic                    s_last,
  output logic                    s_ready,
  input  logic [7:0]              frame_beats,
  output logic [LANES*BYTE_W-1:0] out_data,
  output logic [7:0]              count,
  output logic                    beat_valid,
  output logic                    frame_done,
  output logic                    err_short,
  output logic                    err_long
);

  localparam int IDX_W = idx_w(LANES);
  localparam int DW    = LANES * BYTE_W;

  state_t           r_state, w_next;
  logic             r_alive;
  logic [7:0]       r_beats, r_beat_idx, r_count;
  logic [IDX_W-1:0] r_byte_idx;
  logic [DW-1:0]    r_out_data, w_fill, w_merged;
  logic             r_beat_valid, r_frame_done, r_err_short, r_err_long;

  logic             w_xfer, w_start, w_last_lane, w_final_beat;
  logic             w_emit, w_end, w_short, w_long;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_beat, w_beats;

  assign s_ready = r_alive && (r_state != ST_DONE);
  assign w_xfer  = s_valid && s_ready;
  assign w_start = w_xfer && (r_state == ST_IDLE);

  // In IDLE the incoming byte is lane 0 of beat 0 of a fresh frame.
  assign w_idx   = (r_state == ST_IDLE) ? '0 : r_byte_idx;
  assign w_beat  = (r_state == ST_IDLE) ? 8'd0 : r_beat_idx;
  assign w_beats = (r_state == ST_IDLE) ? ((frame_beats == 8'd0) ? 8'd1 : frame_beats)
                                        : r_beats;

  assign w_last_lane  = (w_idx == IDX_W'(LANES - 1));
  assign w_final_beat = (w_beat == w_beats - 8'd1);
  assign w_short = w_xfer && s_last && !(w_last_lane && w_final_beat);
  assign w_long  = w_xfer && !s_last && w_last_lane && w_final_beat;
  assign w_emit  = w_xfer && (w_last_lane || s_last);
  assign w_end   = w_xfer && (s_last || (w_last_lane && w_final_beat));

  lane_buffer #(
    .LANES  (LANES),
    .BYTE_W (BYTE_W),
    .IDX_W  (IDX_W)
  ) u_lane_buffer (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (w_start),
    .i_we    (w_xfer),
    .i_idx   (w_idx),
    .i_data  (s_data),
    .o_data  (w_fill)
  );

  // Beat image as it will be once this byte lands; lanes past it read as zero padding.
  always_comb begin
    w_merged = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(w_idx))
        w_merged[k*BYTE_W +: BYTE_W] = w_fill[k*BYTE_W +: BYTE_W];
      else if (k == int'(w_idx))
        w_merged[k*BYTE_W +: BYTE_W] = s_data;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_FILL: begin
        if (w_end)        w_next = ST_DONE;
        else if (w_start) w_next = ST_FILL;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alive      <= 1'b0;
      r_beats      <= 8'd1;
      r_beat_idx   <= 8'd0;
      r_byte_idx   <= '0;
      r_out_data   <= '0;
      r_count      <= 8'd0;
      r_beat_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_short  <= 1'b0;
      r_err_long   <= 1'b0;
    end else begin
      r_alive      <= 1'b1;
      r_beat_valid <= w_emit;
      r_frame_done <= w_end;
      if (w_short) r_err_short <= 1'b1;
      if (w_long)  r_err_long  <= 1'b1;
      if (w_start) r_beats     <= w_beats;
      if (w_xfer) begin
        if (w_emit) begin
          r_out_data <= w_merged;
          r_count    <= w_beat;
          r_beat_idx <= w_beat + 8'd1;
          r_byte_idx <= '0;
        end else begin
          r_beat_idx <= w_beat;
          r_byte_idx <= w_idx + IDX_W'(1);
        end
      end
    end
  end

  assign out_data   = r_out_data;
  assign count      = r_count;
  assign beat_valid = r_beat_valid;
  assign frame_done = r_frame_done;
  assign err_short  = r_err_short;
  assign err_long   = r_err_long;

endmodule

// File: tb/tb_nn_beat_loader.sv
// tb/tb_nn_beat_loader.sv - directed self-checking bench for nn_beat_loader
module tb_nn_beat_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         s_valid = 1'b0;
  logic [7:0]   s_data = 8'd0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [7:0]   frame_beats = 8'd1;
  logic [399:0] out_data;
  logic [7:0]   count;
  logic         beat_valid, frame_done, err_short, err_long;

  int n_checks = 0;
  int n_errors = 0;
  int n_done = 0;
  int n_unstable = 0;
  int n_timeout = 0;
  logic [7:0]   q_cnt[$];
  logic [399:0] q_data[$];
  logic [399:0] prev_data = '0;
  logic [7:0]   prev_cnt = '0;

  nn_beat_loader dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .frame_beats (frame_beats),
    .out_data    (out_data),
    .count       (count),
    .beat_valid  (beat_valid),
    .frame_done  (frame_done),
    .err_short   (err_short),
    .err_long    (err_long)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (beat_valid) begin
        q_cnt.push_back(count);
        q_data.push_back(out_data);
      end
      if (frame_done) n_done++;
      if (!beat_valid && (out_data !== prev_data || count !== prev_cnt)) n_unstable++;
    end
    prev_data = out_data;
    prev_cnt  = count;
  end

  function automatic logic [7:0] lane(input logic [399:0] d, input int k);
    return d[(k-1)*8 +: 8];
  endfunction

  task automatic clear_log();
    q_cnt.delete();
    q_data.delete();
    n_done = 0;
    n_unstable = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) n_timeout++;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(2);
    n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL rst_s_ready got %b want 0", s_ready); end
    n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_checks++; if (count !== 8'd0) begin n_errors++; $display("FAIL rst_count got %0d want 0", count); end
    n_checks++; if ({beat_valid, frame_done, err_short, err_long} !== 4'b0) begin n_errors++; $display("FAIL rst_flags got %b want 0000", {beat_valid, frame_done, err_short, err_long}); end
    @(negedge clk); reset = 1'b1; #1;
    n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready_before_edge got %b want 0", s_ready); end
    @(posedge clk); #1;
    n_checks++; if (s_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready_after_edge got %b want 1", s_ready); end
  endtask

  task automatic test_feature_frame();
    int bad = 0;
    clear_log();
    frame_beats = 8'd20;
    for (int i = 0; i < 1000; i++) send_byte(8'(i), i == 999);
    idle(3);
    for (int i = 0; i < q_cnt.size(); i++) if (q_cnt[i] !== 8'(i)) bad++;
    n_checks++; if (q_cnt.size() != 20) begin n_errors++; $display("FAIL feat_beats got %0d want 20", q_cnt.size()); end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL feat_count_seq got %0d bad want 0", bad); end
    n_checks++; if (lane(q_data[19], 1) !== 8'hB6) begin n_errors++; $display("FAIL feat_b19_lane1 got %h want b6", lane(q_data[19], 1)); end
    n_checks++; if (lane(q_data[0], 50) !== 8'h31) begin n_errors++; $display("FAIL feat_b0_lane50 got %h want 31", lane(q_data[0], 50)); end
    n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL feat_done got %0d want 1", n_done); end
    n_checks++; if ({err_short, err_long} !== 2'b00) begin n_errors++; $display("FAIL feat_errs got %b want 00", {err_short, err_long}); end
    n_checks++; if (n_unstable != 0) begin n_errors++; $display("FAIL feat_stable got %0d want 0", n_unstable); end
  endtask

  task automatic test_layer1_gapped();
    int bad = 0;
    clear_log();
    frame_beats = 8'd3;
    for (int i = 0; i < 150; i++) begin
      send_byte(8'(i * 7 + 3), i == 149);
      idle(1);
    end
    idle(3);
    for (int i = 0; i < q_cnt.size(); i++) if (q_cnt[i] !== 8'(i)) bad++;
    n_checks++; if (q_cnt.size() != 3) begin n_errors++; $display("FAIL l1_beats got %0d want 3", q_cnt.size()); end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL l1_count_seq got %0d bad want 0", bad); end
    n_checks++; if (lane(q_data[2], 1) !== 8'hBF) begin n_errors++; $display("FAIL l1_b2_lane1 got %h want bf", lane(q_data[2], 1)); end
    n_checks++; if (lane(q_data[1], 50) !== 8'hB8) begin n_errors++; $display("FAIL l1_b1_lane50 got %h want b8", lane(q_data[1], 50)); end
    n_checks++; if (n_unstable != 0) begin n_errors++; $display("FAIL l1_stable got %0d want 0", n_unstable); end
    n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL l1_done got %0d want 1", n_done); end
  endtask

  task automatic test_short_frame();
    clear_log();
    frame_beats = 8'd3;
    for (int i = 0; i < 75; i++) send_byte(8'(i + 1), i == 74);
    idle(3);
    n_checks++; if (q_cnt.size() != 2) begin n_errors++; $display("FAIL short_beats got %0d want 2", q_cnt.size()); end
    n_checks++; if (q_cnt[1] !== 8'd1) begin n_errors++; $display("FAIL short_count got %0d want 1", q_cnt[1]); end
    n_checks++; if (lane(q_data[1], 25) !== 8'h4B) begin n_errors++; $display("FAIL short_lane25 got %h want 4b", lane(q_data[1], 25)); end
    n_checks++; if (q_data[1][399:200] !== '0) begin n_errors++; $display("FAIL short_pad got %h want 0", q_data[1][399:200]); end
    n_checks++; if ({err_short, err_long} !== 2'b10) begin n_errors++; $display("FAIL short_errs got %b want 10", {err_short, err_long}); end
    n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL short_done got %0d want 1", n_done); end
  endtask

  task automatic test_long_frame();
    clear_log();
    frame_beats = 8'd1;
    for (int i = 0; i < 50; i++) send_byte(8'hC0 ^ 8'(i), 1'b0);
    n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL long_ready_done got %b want 0", s_ready); end
    n_checks++; if ({beat_valid, frame_done} !== 2'b11) begin n_errors++; $display("FAIL long_pulses got %b want 11", {beat_valid, frame_done}); end
    n_checks++; if (err_long !== 1'b1) begin n_errors++; $display("FAIL long_err_long got %b want 1", err_long); end
    idle(3);
    n_checks++; if (err_short !== 1'b1) begin n_errors++; $display("FAIL long_short_sticky got %b want 1", err_short); end
    n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL long_done got %0d want 1", n_done); end
    n_checks++; if (lane(q_data[0], 50) !== 8'hF1) begin n_errors++; $display("FAIL long_lane50 got %h want f1", lane(q_data[0], 50)); end
    n_checks++; if (s_ready !== 1'b1) begin n_errors++; $display("FAIL long_ready_idle got %b want 1", s_ready); end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    frame_beats = 8'd2;
    for (int i = 0; i < 31; i++) send_byte(8'h55, 1'b0);
    reset = 1'b0; #1;
    n_checks++; if (out_data !== '0 || count !== 8'd0) begin n_errors++; $display("FAIL mid_rst_data got %h/%0d want 0/0", out_data, count); end
    n_checks++; if ({s_ready, beat_valid, frame_done, err_short, err_long} !== 5'b0) begin n_errors++; $display("FAIL mid_rst_flags got %b want 00000", {s_ready, beat_valid, frame_done, err_short, err_long}); end
    idle(2);
    @(negedge clk); reset = 1'b1;
    idle(2);
    n_checks++; if (q_cnt.size() != 0) begin n_errors++; $display("FAIL mid_no_beat got %0d want 0", q_cnt.size()); end
    frame_beats = 8'd1;
    for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i), i == 9);
    idle(3);
    n_checks++; if (q_cnt.size() != 1 || q_cnt[0] !== 8'd0) begin n_errors++; $display("FAIL mid_next_count got %0d beats count %0d want 1/0", q_cnt.size(), q_cnt[0]); end
    n_checks++; if (lane(q_data[0], 10) !== 8'h19) begin n_errors++; $display("FAIL mid_lane10 got %h want 19", lane(q_data[0], 10)); end
    n_checks++; if (q_data[0][399:80] !== '0) begin n_errors++; $display("FAIL mid_clean got %h want 0", q_data[0][399:80]); end
    n_checks++; if ({err_short, err_long} !== 2'b10) begin n_errors++; $display("FAIL mid_errs got %b want 10", {err_short, err_long}); end
  endtask

  task automatic test_zero_beats();
    clear_log();
    frame_beats = 8'd0;
    for (int i = 0; i < 50; i++) send_byte(8'(i), i == 49);
    idle(3);
    n_checks++; if (q_cnt.size() != 1) begin n_errors++; $display("FAIL zero_beats got %0d want 1", q_cnt.size()); end
    n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL zero_done got %0d want 1", n_done); end
    n_checks++; if (err_long !== 1'b0) begin n_errors++; $display("FAIL zero_err_long got %b want 0", err_long); end
    n_checks++; if (lane(q_data[0], 50) !== 8'h31) begin n_errors++; $display("FAIL zero_lane50 got %h want 31", lane(q_data[0], 50)); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_feature_frame();
    test_layer1_gapped();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_zero_beats();
    n_checks++; if (n_timeout != 0) begin n_errors++; $display("FAIL ready_timeouts got %0d want 0", n_timeout); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nn_beat_loader.md
NN_BEAT_LOADER -- requirements
Module: nn_beat_loader

Interface
REQ-001 SHALL have parameter LANES, default 50, meaning bytes per beat.
REQ-002 SHALL have parameter BYTE_W, default 8, meaning lane width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port s_valid, input, 1, byte-stream valid.
REQ-006 SHALL have port s_data, input, 8, byte-stream payload.
REQ-007 SHALL have port s_last, input, 1, which marks the final byte of a frame.
REQ-008 SHALL have port s_ready, output, 1, byte-stream ready.
REQ-009 SHALL have port frame_beats, input, 8, the beat count per frame (20 for features, 21 for layer-0 weights, 3 for layer-1 weights).
REQ-010 SHALL have port out_data, output, LANES*8, the packed beat; lane k (1-based) sits at bits [8k-1:8k-8].
REQ-011 SHALL have port count, output, 8, the beat index of out_data within the frame.
REQ-012 SHALL have port beat_valid, output, 1, a one-cycle pulse when out_data/count update.
REQ-013 SHALL have port frame_done, output, 1, a one-cycle pulse after the final beat of a frame.
REQ-014 SHALL have ports err_short and err_long, output, 1 each, sticky frame-length error flags.

Function
REQ-015 SHALL implement states IDLE, FILL, DONE; s_ready=1 in IDLE/FILL and 0 in DONE; a byte transfers on s_valid&&s_ready.
REQ-016 SHALL, on the first transfer in IDLE, latch frame_beats (0 treated as 1), clear the beat index and byte index, and go to FILL.
REQ-017 SHALL write each transferred byte into fill-buffer lane byte_idx, byte_idx 0..LANES-1, without disturbing out_data.
REQ-018 SHALL, when byte_idx LANES-1 transfers at edge t, copy the fill buffer to out_data, set count=beat index, and pulse beat_valid at t+1 (1-cycle latency).
REQ-019 SHALL hold out_data and count stable between beats, since the consumer samples them every cycle.
REQ-020 SHALL increment the beat index after each completed beat and wrap byte_idx to 0.
REQ-021 SHALL, on completion of beat latched_beats-1, go to DONE, pulse frame_done for one cycle, then return to IDLE.
REQ-022 SHALL, on s_last before the final byte of the final beat, zero-pad the remaining lanes, emit the beat, set err_short, and go to DONE.
REQ-023 SHALL, when s_last is low on the final byte of the final beat, set err_long and still end the frame at DONE.
REQ-024 SHALL, when s_valid is low in FILL, hold all state (no timeout).
REQ-025 SHALL clear the fill buffer to zero at each frame start.
REQ-026 SHALL clear err_short/err_long only by reset.

Reset
REQ-027 SHALL, while reset is low: state=IDLE, s_ready=0, out_data=0, count=0, beat_valid=0, frame_done=0, err flags=0, fill buffer=0.
REQ-028 SHALL raise s_ready on the first clk edge after reset deasserts.
REQ-029 SHALL, on reset mid-frame, discard the partial frame and emit no beat.

Structure
REQ-030 SHALL take LANES, BYTE_W and the state encoding from shared package nn_pkg.
REQ-031 SHALL use one sub-module, lane_buffer: a LANES x 8 fill register with indexed write and synchronous clear.

Verification
REQ-032 SHALL cover a full feature frame: frame_beats=20, 1000 bytes, byte value=index mod 256, s_last on the last byte -> 20 beat_valid pulses, count 0..19, lane1 of beat 19 = 0xB6, frame_done once, no errors.
REQ-033 SHALL cover a layer-1 weight frame: frame_beats=3, 150 bytes with s_valid toggled every other cycle -> beats at count 0,1,2; out_data unchanged between pulses.
REQ-034 SHALL cover a short frame: frame_beats=3, s_last on byte 74 -> beat count=1 with lanes 26..50 = 0, err_short=1, frame_done.
REQ-035 SHALL cover a long frame: frame_beats=1, s_last low on byte 49 -> err_long=1, frame_done; s_ready=0 in the DONE cycle.
REQ-036 SHALL cover reset mid-frame: reset low after byte 30 -> all outputs 0; the next frame starts at count 0 with a clean buffer.
